// File: rtl/wf68k30l_data_register_bank.sv
// rtl/wf68k30l_data_register_bank.sv - multi-port data register file with writeback reservation scoreboard
package wf68k30l_pkg;
    localparam logic [1:0] BYTE = 2'b00;
    localparam logic [1:0] WORD = 2'b01;
    localparam logic [1:0] LONG = 2'b10;
endpackage

module wf68k30l_data_register_bank
    import wf68k30l_pkg::*;
#(
    parameter int NUM_REGS = 8,
    parameter int RD_PORTS = 2,
    parameter int WR_PORTS = 2,
    parameter int SB_DEPTH = 4,
    parameter int BYPASS   = 0,
    localparam int SEL_W   = $clog2(NUM_REGS)
) (
    input  logic                      CLK,
    input  logic                      RESET_N,
    input  logic [32*WR_PORTS-1:0]    DR_IN,
    output logic [32*RD_PORTS-1:0]    DR_OUT,
    input  logic [SEL_W*RD_PORTS-1:0] DR_SEL_RD,
    input  logic [RD_PORTS-1:0]       DR_RD_EN,
    input  logic [SEL_W*WR_PORTS-1:0] DR_SEL_WR,
    input  logic                      DR_MARK_USED,
    input  logic [WR_PORTS-1:0]       DR_MARK_EN,
    input  logic [WR_PORTS-1:0]       DR_WR,
    input  logic [2*WR_PORTS-1:0]     OP_SIZE,
    input  logic                      UNMARK,
    output logic                      DR_IN_USE,
    output logic                      SB_FULL,
    output logic                      SB_EMPTY,
    output logic                      SB_ERR
);
    localparam int PTR_W = $clog2(SB_DEPTH);
    localparam int CNT_W = PTR_W + 1;

    logic [31:0]               regs     [NUM_REGS];
    logic [WR_PORTS-1:0]       sb_mask  [SB_DEPTH];
    logic [SEL_W*WR_PORTS-1:0] sb_sel   [SB_DEPTH];
    logic [SB_DEPTH-1:0]       sb_valid;
    logic [PTR_W-1:0]          head;
    logic [PTR_W-1:0]          tail;
    logic [CNT_W-1:0]          count;
    logic [CNT_W-1:0]          count_nxt;

    logic                      is_empty;
    logic                      is_full;
    logic                      pop_ok;
    logic                      push_ok;
    logic                      err_c;
    logic [WR_PORTS-1:0]       head_mask;
    logic [SEL_W*WR_PORTS-1:0] head_sel;
    logic [WR_PORTS-1:0]       wr_ok;
    logic [3:0]                lane_en  [WR_PORTS];

    assign is_empty  = (count == '0);
    assign is_full   = (count == CNT_W'(SB_DEPTH));
    assign head_mask = sb_mask[head];
    assign head_sel  = sb_sel[head];

    // A pop on an empty queue is ignored; a push on a full queue only lands if the head leaves.
    assign pop_ok    = UNMARK && !is_empty;
    assign push_ok   = DR_MARK_USED && (!is_full || pop_ok);
    assign count_nxt = count + CNT_W'(push_ok) - CNT_W'(pop_ok);

    always_comb begin
        wr_ok = '0;
        err_c = (DR_MARK_USED && is_full && !UNMARK) || (UNMARK && is_empty && !DR_MARK_USED);
        for (int p = 0; p < WR_PORTS; p++) begin
            case (OP_SIZE[2*p +: 2])
                LONG:    lane_en[p] = 4'b1111;
                WORD:    lane_en[p] = 4'b0011;
                BYTE:    lane_en[p] = 4'b0001;
                default: lane_en[p] = 4'b0000;
            endcase
            if (DR_WR[p]) begin
                if (is_empty || !head_mask[p]) begin
                    err_c = 1'b1;
                end else begin
                    wr_ok[p] = 1'b1;
                end
            end
        end
    end

    // Ports are visited in ascending order so the highest-index writer owns overlapping lanes.
    always_ff @(posedge CLK or negedge RESET_N) begin
        if (!RESET_N) begin
            for (int i = 0; i < NUM_REGS; i++) begin
                regs[i] <= '0;
            end
        end else begin
            for (int p = 0; p < WR_PORTS; p++) begin
                for (int b = 0; b < 4; b++) begin
                    if (wr_ok[p] && lane_en[p][b]) begin
                        regs[head_sel[SEL_W*p +: SEL_W]][8*b +: 8] <= DR_IN[32*p + 8*b +: 8];
                    end
                end
            end
        end
    end

    always_ff @(posedge CLK or negedge RESET_N) begin
        if (!RESET_N) begin
            head     <= '0;
            tail     <= '0;
            count    <= '0;
            sb_valid <= '0;
            SB_FULL  <= 1'b0;
            SB_EMPTY <= 1'b1;
            SB_ERR   <= 1'b0;
            for (int i = 0; i < SB_DEPTH; i++) begin
                sb_mask[i] <= '0;
                sb_sel[i]  <= '0;
            end
        end else begin
            if (pop_ok) begin
                sb_valid[head] <= 1'b0;
                head           <= head + 1'b1;
            end
            // Placed after the pop so a full-queue push+pop into the freed slot stays valid.
            if (push_ok) begin
                sb_valid[tail] <= 1'b1;
                sb_mask[tail]  <= DR_MARK_EN;
                sb_sel[tail]   <= DR_SEL_WR;
                tail           <= tail + 1'b1;
            end
            count    <= count_nxt;
            SB_FULL  <= (count_nxt == CNT_W'(SB_DEPTH));
            SB_EMPTY <= (count_nxt == '0);
            if (err_c) begin
                SB_ERR <= 1'b1;
            end
        end
    end

    always_comb begin
        DR_OUT = '0;
        for (int r = 0; r < RD_PORTS; r++) begin
            DR_OUT[32*r +: 32] = regs[DR_SEL_RD[SEL_W*r +: SEL_W]];
            if (BYPASS != 0) begin
                for (int p = 0; p < WR_PORTS; p++) begin
                    for (int b = 0; b < 4; b++) begin
                        if (wr_ok[p] && lane_en[p][b] &&
                            head_sel[SEL_W*p +: SEL_W] == DR_SEL_RD[SEL_W*r +: SEL_W]) begin
                            DR_OUT[32*r + 8*b +: 8] = DR_IN[32*p + 8*b +: 8];
                        end
                    end
                end
            end
        end
    end

    always_comb begin
        DR_IN_USE = 1'b0;
        for (int i = 0; i < SB_DEPTH; i++) begin
            for (int p = 0; p < WR_PORTS; p++) begin
                for (int r = 0; r < RD_PORTS; r++) begin
                    if (sb_valid[i] && sb_mask[i][p] && DR_RD_EN[r] &&
                        sb_sel[i][SEL_W*p +: SEL_W] == DR_SEL_RD[SEL_W*r +: SEL_W]) begin
                        DR_IN_USE = 1'b1;
                    end
                end
            end
        end
    end
endmodule

// File: tb/tb_wf68k30l_data_register_bank.sv
// tb/tb_wf68k30l_data_register_bank.sv - randomized and directed check of the data register bank
module tb_wf68k30l_data_register_bank;
    import wf68k30l_pkg::*;

    logic        clk = 1'b0;
    logic        reset_n;
    logic [63:0] dr_in;
    logic [5:0]  dr_sel_rd;
    logic [1:0]  dr_rd_en;
    logic [5:0]  dr_sel_wr;
    logic        mark;
    logic [1:0]  mark_en;
    logic [1:0]  dr_wr;
    logic [3:0]  op_size;
    logic        unmark;

    logic [63:0] out_nb, out_bp;
    logic        use_nb, use_bp, full_nb, full_bp, empty_nb, empty_bp, err_nb, err_bp;

    always #5 clk = ~clk;

    wf68k30l_data_register_bank #(.BYPASS(0)) u_nb (
        .CLK(clk), .RESET_N(reset_n), .DR_IN(dr_in), .DR_OUT(out_nb),
        .DR_SEL_RD(dr_sel_rd), .DR_RD_EN(dr_rd_en), .DR_SEL_WR(dr_sel_wr),
        .DR_MARK_USED(mark), .DR_MARK_EN(mark_en), .DR_WR(dr_wr), .OP_SIZE(op_size),
        .UNMARK(unmark), .DR_IN_USE(use_nb), .SB_FULL(full_nb), .SB_EMPTY(empty_nb),
        .SB_ERR(err_nb)
    );

    wf68k30l_data_register_bank #(.BYPASS(1)) u_bp (
        .CLK(clk), .RESET_N(reset_n), .DR_IN(dr_in), .DR_OUT(out_bp),
        .DR_SEL_RD(dr_sel_rd), .DR_RD_EN(dr_rd_en), .DR_SEL_WR(dr_sel_wr),
        .DR_MARK_USED(mark), .DR_MARK_EN(mark_en), .DR_WR(dr_wr), .OP_SIZE(op_size),
        .UNMARK(unmark), .DR_IN_USE(use_bp), .SB_FULL(full_bp), .SB_EMPTY(empty_bp),
        .SB_ERR(err_bp)
    );

    typedef struct packed {
        logic [1:0] mask;
        logic [5:0] sel;
    } rec_t;

    logic [31:0] m_regs [8];
    logic [31:0] m_next [8];
    rec_t        m_q [$];
    logic        m_err;
    logic        m_err_now;

    int vectors = 0;
    int miscompares = 0;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        vectors++;
        if (got !== exp) begin
            miscompares++;
            $display("FAIL %s got=%08h exp=%08h at %0t", tag, got, exp, $time);
        end
    endtask

    task automatic idle();
        dr_in     = '0;
        dr_sel_rd = '0;
        dr_rd_en  = '0;
        dr_sel_wr = '0;
        mark      = 1'b0;
        mark_en   = '0;
        dr_wr     = '0;
        op_size   = '0;
        unmark    = 1'b0;
    endtask

    task automatic model_clear();
        for (int i = 0; i < 8; i++) m_regs[i] = '0;
        m_q.delete();
        m_err = 1'b0;
    endtask

    // Register contents after this cycle's writes, plus any write-protocol violation.
    task automatic model_writes();
        rec_t h;
        logic [2:0] s;
        for (int i = 0; i < 8; i++) m_next[i] = m_regs[i];
        m_err_now = 1'b0;
        for (int p = 0; p < 2; p++) begin
            if (dr_wr[p]) begin
                if (m_q.size() == 0) begin
                    m_err_now = 1'b1;
                end else begin
                    h = m_q[0];
                    if (!h.mask[p]) begin
                        m_err_now = 1'b1;
                    end else begin
                        s = h.sel[3*p +: 3];
                        case (op_size[2*p +: 2])
                            LONG:    m_next[s]       = dr_in[32*p +: 32];
                            WORD:    m_next[s][15:0] = dr_in[32*p +: 16];
                            BYTE:    m_next[s][7:0]  = dr_in[32*p +: 8];
                            default: ;
                        endcase
                    end
                end
            end
        end
    endtask

    function automatic logic model_in_use();
        logic u = 1'b0;
        foreach (m_q[i])
            for (int p = 0; p < 2; p++)
                for (int r = 0; r < 2; r++)
                    if (m_q[i].mask[p] && dr_rd_en[r] && m_q[i].sel[3*p +: 3] == dr_sel_rd[3*r +: 3])
                        u = 1'b1;
        return u;
    endfunction

    task automatic check_flags();
        check("full_nb",  32'(full_nb),  32'(m_q.size() == 4));
        check("full_bp",  32'(full_bp),  32'(m_q.size() == 4));
        check("empty_nb", 32'(empty_nb), 32'(m_q.size() == 0));
        check("empty_bp", 32'(empty_bp), 32'(m_q.size() == 0));
        check("err_nb",   32'(err_nb),   32'(m_err));
        check("err_bp",   32'(err_bp),   32'(m_err));
    endtask

    // Inputs are already driven at the falling edge; returns at the next falling edge.
    task automatic step();
        logic pop, push;
        rec_t rec;
        #2;
        model_writes();
        for (int r = 0; r < 2; r++) begin
            check("out_nb", out_nb[32*r +: 32], m_regs[dr_sel_rd[3*r +: 3]]);
            check("out_bp", out_bp[32*r +: 32], m_next[dr_sel_rd[3*r +: 3]]);
        end
        check("in_use_nb", 32'(use_nb), 32'(model_in_use()));
        check("in_use_bp", 32'(use_bp), 32'(model_in_use()));
        @(posedge clk);
        for (int i = 0; i < 8; i++) m_regs[i] = m_next[i];
        pop  = unmark && m_q.size() > 0;
        push = mark && (m_q.size() < 4 || pop);
        if (m_err_now) m_err = 1'b1;
        if (mark && m_q.size() == 4 && !unmark) m_err = 1'b1;
        if (unmark && m_q.size() == 0 && !mark) m_err = 1'b1;
        rec.mask = mark_en;
        rec.sel  = dr_sel_wr;
        if (pop) void'(m_q.pop_front());
        if (push) m_q.push_back(rec);
        #1;
        check_flags();
        @(negedge clk);
    endtask

    task automatic do_reset();
        idle();
        reset_n = 1'b0;
        model_clear();
        @(negedge clk);
        @(negedge clk);
        check_flags();
        check("rst_use", 32'(use_nb), 32'd0);
        reset_n = 1'b1;
    endtask

    task automatic do_mark(input logic [1:0] en, input logic [2:0] s1, input logic [2:0] s0);
        idle();
        mark = 1'b1; mark_en = en; dr_sel_wr = {s1, s0};
        step();
    endtask

    // Write through the head record and retire it in the same cycle, reading back sel rd0.
    task automatic do_write(input logic [1:0] wr, input logic [3:0] sz, input logic [63:0] d,
                            input logic [2:0] rd0);
        idle();
        dr_wr = wr; op_size = sz; dr_in = d; unmark = 1'b1; dr_sel_rd = {3'd0, rd0};
        step();
    endtask

    task automatic do_read(input logic [2:0] rd0, input logic en);
        idle();
        dr_sel_rd = {3'd0, rd0}; dr_rd_en = {1'b0, en};
        step();
    endtask

    initial begin
        reset_n = 1'b0;
        idle();
        @(negedge clk);
        do_reset();

        // LONG write to D3
        do_mark(2'b01, 3'd0, 3'd3);
        do_write(2'b01, {BYTE, LONG}, 64'h12345678, 3'd3);
        do_read(3'd3, 1'b0);
        check("d3_long", out_nb[31:0], 32'h12345678);

        // D5 LONG, then WORD, then BYTE through port 1
        do_mark(2'b10, 3'd5, 3'd0);
        do_write(2'b10, {LONG, BYTE}, {32'hAABBCCDD, 32'h0}, 3'd5);
        do_mark(2'b10, 3'd5, 3'd0);
        do_write(2'b10, {WORD, BYTE}, {32'hFFFF1111, 32'h0}, 3'd5);
        do_read(3'd5, 1'b0);
        check("d5_word", out_nb[31:0], 32'hAABB1111);
        do_mark(2'b10, 3'd5, 3'd0);
        do_write(2'b10, {BYTE, BYTE}, {32'hFFFFFF22, 32'h0}, 3'd5);
        do_read(3'd5, 1'b0);
        check("d5_byte", out_nb[31:0], 32'hAABB1122);

        // Fill scoreboard, overflow push dropped
        for (int i = 0; i < 4; i++) do_mark(2'b01, 3'd0, 3'(i));
        do_mark(2'b01, 3'd0, 3'd4);
        check("ovf_full", 32'(full_nb), 32'd1);
        check("ovf_err", 32'(err_nb), 32'd1);
        do_read(3'd4, 1'b1);
        check("ovf_d4_free", 32'(use_nb), 32'd0);
        do_read(3'd2, 1'b1);
        for (int i = 0; i < 4; i++) begin
            idle(); unmark = 1'b1; step();
        end
        do_reset();

        // Two-port reservation and read enable qualification
        do_mark(2'b11, 3'd6, 3'd2);
        do_read(3'd6, 1'b1);
        check("d6_in_use", 32'(use_nb), 32'd1);
        do_read(3'd6, 1'b0);
        idle(); unmark = 1'b1; step();
        do_read(3'd6, 1'b1);

        // Same-cycle bypass on BYTE write to D1
        do_mark(2'b01, 3'd0, 3'd1);
        do_write(2'b01, {BYTE, BYTE}, 64'h7F, 3'd1);
        do_read(3'd1, 1'b0);
        check("d1_after", out_nb[31:0], 32'h0000007F);

        // Two ports write D4, highest port wins overlapping lane
        do_mark(2'b11, 3'd4, 3'd4);
        do_write(2'b11, {BYTE, LONG}, {32'h00000001, 32'hFFFFFFFF}, 3'd4);
        do_read(3'd4, 1'b0);
        check("d4_merge", out_nb[31:0], 32'hFFFFFF01);
        do_write(2'b11, {LONG, LONG}, 64'h0, 3'd4);
        check("empty_wr_err", 32'(err_nb), 32'd1);

        // Randomized traffic with periodic resets to re-arm the sticky error
        for (int n = 0; n < 600; n++) begin
            if (n % 150 == 0) do_reset();
            idle();
            dr_in     = {$urandom, $urandom};
            dr_sel_rd = 6'($urandom);
            dr_rd_en  = 2'($urandom);
            dr_sel_wr = 6'($urandom);
            mark      = ($urandom_range(0, 99) < 45);
            mark_en   = 2'($urandom);
            unmark    = ($urandom_range(0, 99) < 40);
            op_size   = 4'($urandom);
            if (m_q.size() > 0) dr_wr = m_q[0].mask & 2'($urandom);
            if ($urandom_range(0, 99) < 3) dr_wr = 2'($urandom);
            if (m_q.size() == 4 && $urandom_range(0, 99) < 90) unmark = 1'b1;
            step();
        end

        // Asynchronous reset mid-operation
        do_mark(2'b01, 3'd0, 3'd7);
        dr_sel_rd = 6'd7;
        #3;
        reset_n = 1'b0;
        #1;
        model_clear();
        check("async_empty", 32'(empty_nb), 32'd1);
        check("async_data", out_bp[31:0], 32'd0);
        @(negedge clk);
        reset_n = 1'b1;
        do_read(3'd7, 1'b1);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end
endmodule
